// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential 32x32 -> 32 (low word) shift-and-add multiplier that
// borrows an external combinational ALU for every add and shift.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                request a multiply (accepted only in IDLE)
//   flush                abort an in-flight multiply (ADD/SHL only)
//   op_a, op_b           multiplicand / multiplier, captured on accepted start
//   busy                 high from the cycle after start through the DONE cycle
//   done                 one-cycle pulse, result valid
//   result               low 32 bits of op_a*op_b, held until the next result
//   alu_A, alu_B,
//   alu_Imm, alu_PC_out  ALU operand drives
//   alu_Asel, alu_Bsel   1 selects alu_A / alu_B, 0 selects alu_PC_out / alu_Imm
//   alu_ALUop            00000 add, 00010 shift-left-logical
//   alu_value            ALU result for the current drives
//
// state | meaning
// IDLE  | waiting for start
// ADD   | acc + mcand through the ALU, kept if mplier[0] is set
// SHL   | mcand << 1 through the ALU, mplier >> 1, count the pass
// DONE  | result valid, done pulse
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [31:0] alu_Imm,
    output logic [31:0] alu_PC_out,
    output logic        alu_Asel,
    output logic        alu_Bsel,
    output logic [4:0]  alu_ALUop,
    input  logic [31:0] alu_value
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SLL = 5'b00010;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHL, S_DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
    logic        last_pass;

    // Stop once no set multiplier bits remain, or after all 32 passes.
    assign last_pass = (cnt == 5'd31) || (mplier[31:1] == 31'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_A      = 32'd0;
        alu_B      = 32'd0;
        alu_Imm    = 32'd0;
        alu_PC_out = 32'd0;
        alu_Asel   = 1'b0;
        alu_Bsel   = 1'b0;
        alu_ALUop  = OP_ADD;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ADD;
            end
            S_ADD: begin
                busy      = 1'b1;
                alu_A     = acc;
                alu_B     = mcand;
                alu_Asel  = 1'b1;
                alu_Bsel  = 1'b1;
                alu_ALUop = OP_ADD;
                state_nxt = flush ? S_IDLE : S_SHL;
            end
            S_SHL: begin
                busy      = 1'b1;
                alu_A     = mcand;
                alu_Imm   = 32'd1;
                alu_Asel  = 1'b1;
                alu_Bsel  = 1'b0;
                alu_ALUop = OP_SLL;
                if (flush)          state_nxt = S_IDLE;
                else if (last_pass) state_nxt = S_DONE;
                else                state_nxt = S_ADD;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= 32'd0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= 5'd0;
                    end
                end
                S_ADD: begin
                    if (!flush && mplier[0]) acc <= alu_value;
                end
                S_SHL: begin
                    if (!flush) begin
                        mcand  <= alu_value;
                        mplier <= {1'b0, mplier[31:1]};
                        cnt    <= cnt + 5'd1;
                        // acc is final here, so result is already valid in DONE.
                        if (last_pass) result <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
